// File: rtl/pipe_reg_em_skid_if.sv
// rtl/pipe_reg_em_skid_if.sv - EX->MEM stage register handshake and data bundle
interface pipe_reg_em_skid_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
);
   logic              flush_i;
   logic              valid_i;
   logic              ready_o;
   logic [CTRL_W-1:0] ctrl_i;
   logic [DATA_W-1:0] alu_result_i;
   logic [DATA_W-1:0] write_data_i;
   logic [ADDR_W-1:0] wa3_i;
   logic              valid_o;
   logic              ready_i;
   logic [CTRL_W-1:0] ctrl_o;
   logic [DATA_W-1:0] alu_result_o;
   logic [DATA_W-1:0] write_data_o;
   logic [ADDR_W-1:0] wa3_o;
   logic [1:0]        count_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   modport slave (
      input  flush_i, valid_i, ctrl_i, alu_result_i, write_data_i, wa3_i, ready_i,
      output ready_o, valid_o, ctrl_o, alu_result_o, write_data_o, wa3_o,
             count_o, stall_cnt_o
   );

   modport master (
      output flush_i, valid_i, ctrl_i, alu_result_i, write_data_i, wa3_i, ready_i,
      input  ready_o, valid_o, ctrl_o, alu_result_o, write_data_o, wa3_o,
             count_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_reg_em_skid.sv
// rtl/pipe_reg_em_skid.sv - EX->MEM stage register with 2-entry skid buffer
// ready_o is decoded from state only, so MEM backpressure never reaches EX combinationally.
module pipe_reg_em_skid #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_reg_em_skid_if.slave bus
);
   localparam int ENTRY_W = CTRL_W + 2*DATA_W + ADDR_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [ENTRY_W-1:0]   main_q;
   logic [ENTRY_W-1:0]   skid_q;
   logic [ENTRY_W-1:0]   entry_in;
   logic                 accept;
   logic                 send;
   logic [CNT_W-1:0]     stall_cnt;

   assign entry_in = {bus.ctrl_i, bus.alu_result_i, bus.write_data_i, bus.wa3_i};
   assign accept   = bus.valid_i & bus.ready_o;
   assign send     = bus.valid_o & bus.ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.flush_i) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (accept) state_next = ONE;
            ONE: begin
               if (accept && !send)      state_next = FULL;
               else if (!accept && send) state_next = EMPTY;
            end
            FULL:    if (send) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end
   end

   always_comb begin
      bus.ready_o = (state != FULL);
      bus.valid_o = (state != EMPTY);
      bus.count_o = state;
   end

   // Data registers only move on unflushed transfers; flush leaves stale data behind valid_o=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (!bus.flush_i) begin
         case (state)
            EMPTY: if (accept) main_q <= entry_in;
            ONE: begin
               if (accept && send)  main_q <= entry_in;
               if (accept && !send) skid_q <= entry_in;
            end
            FULL:  if (send) main_q <= skid_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (bus.valid_o && !bus.ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_comb begin
      bus.ctrl_o       = bus.valid_o ? main_q[ENTRY_W-1 -: CTRL_W] : '0;
      bus.alu_result_o = main_q[2*DATA_W+ADDR_W-1 -: DATA_W];
      bus.write_data_o = main_q[DATA_W+ADDR_W-1 -: DATA_W];
      bus.wa3_o        = main_q[ADDR_W-1:0];
      bus.stall_cnt_o  = stall_cnt;
   end
endmodule

// File: tb/tb_pipe_reg_em_skid.sv
// tb/tb_pipe_reg_em_skid.sv - directed self-checking bench for pipe_reg_em_skid
module tb_pipe_reg_em_skid;
   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   pipe_reg_em_skid_if #(.DATA_W(32), .ADDR_W(3), .CTRL_W(4), .CNT_W(4)) bus ();

   pipe_reg_em_skid #(.DATA_W(32), .ADDR_W(3), .CTRL_W(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a);
      bus.valid_i      = v;
      bus.ctrl_i       = c;
      bus.alu_result_i = a;
      bus.write_data_i = a + 32'h100;
      bus.wa3_i        = a[2:0];
   endtask

   initial begin
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b0;
      drive(1'b1, 4'hF, 32'hDEAD);
      #1;
      tick();
      tick();
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_ctrl", 32'(bus.ctrl_o), 32'd0);
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      check("rst_count", 32'(bus.count_o), 32'd0);
      check("rst_stall", 32'(bus.stall_cnt_o), 32'd0);
      check("rst_alu", bus.alu_result_o, 32'd0);
      rst = 1'b0;
      drive(1'b0, 4'h0, 32'h0);

      // streaming
      bus.ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'b0110, 32'h10 + 32'(i));
         tick();
         check("stream_alu", bus.alu_result_o, 32'h10 + 32'(i));
         check("stream_wd", bus.write_data_o, 32'h110 + 32'(i));
         check("stream_wa3", 32'(bus.wa3_o), 32'(3'(i)));
         check("stream_ctrl", 32'(bus.ctrl_o), 32'h6);
         check("stream_ready", 32'(bus.ready_o), 32'd1);
         check("stream_count", 32'(bus.count_o), 32'd1);
      end
      drive(1'b0, 4'h0, 32'h0);
      tick();
      check("drain_count", 32'(bus.count_o), 32'd0);
      check("stream_stall", 32'(bus.stall_cnt_o), 32'd0);

      // backpressure
      bus.ready_i = 1'b0;
      drive(1'b1, 4'b0100, 32'hA0);
      tick();
      check("bp_a_count", 32'(bus.count_o), 32'd1);
      check("bp_a_ready", 32'(bus.ready_o), 32'd1);
      drive(1'b1, 4'b0100, 32'hB0);
      tick();
      check("bp_b_ready", 32'(bus.ready_o), 32'd0);
      check("bp_b_count", 32'(bus.count_o), 32'd2);
      check("bp_b_alu", bus.alu_result_o, 32'hA0);
      drive(1'b1, 4'b0100, 32'hC0);
      tick();
      check("bp_hold_alu", bus.alu_result_o, 32'hA0);
      check("bp_hold_count", 32'(bus.count_o), 32'd2);
      bus.ready_i = 1'b1;
      tick();
      check("bp_out_b", bus.alu_result_o, 32'hB0);
      check("bp_out_b_ready", 32'(bus.ready_o), 32'd1);
      check("bp_out_b_count", 32'(bus.count_o), 32'd1);
      tick();
      check("bp_out_c", bus.alu_result_o, 32'hC0);
      check("bp_out_c_count", 32'(bus.count_o), 32'd1);
      drive(1'b0, 4'h0, 32'h0);
      tick();
      check("bp_empty_valid", 32'(bus.valid_o), 32'd0);
      check("bp_stall", 32'(bus.stall_cnt_o), 32'd2);

      // flush while FULL
      bus.ready_i = 1'b0;
      drive(1'b1, 4'b0100, 32'h1);
      tick();
      drive(1'b1, 4'b0100, 32'h2);
      tick();
      check("fl_full", 32'(bus.count_o), 32'd2);
      check("fl_pre_stall", 32'(bus.stall_cnt_o), 32'd3);
      bus.ready_i = 1'b1;
      bus.flush_i = 1'b1;
      drive(1'b1, 4'b0100, 32'h3);
      tick();
      check("fl_valid", 32'(bus.valid_o), 32'd0);
      check("fl_ctrl", 32'(bus.ctrl_o), 32'd0);
      check("fl_ready", 32'(bus.ready_o), 32'd1);
      check("fl_count", 32'(bus.count_o), 32'd0);
      check("fl_stall", 32'(bus.stall_cnt_o), 32'd3);
      bus.flush_i = 1'b0;
      drive(1'b0, 4'h0, 32'h0);
      tick();
      check("fl_dropped", 32'(bus.valid_o), 32'd0);

      // bubble safety
      bus.ready_i = 1'b0;
      drive(1'b0, 4'hF, 32'h7);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bub_ctrl", 32'(bus.ctrl_o), 32'd0);
         check("bub_valid", 32'(bus.valid_o), 32'd0);
      end
      check("bub_stall", 32'(bus.stall_cnt_o), 32'd3);

      // saturation
      drive(1'b1, 4'b0100, 32'h55);
      tick();
      drive(1'b0, 4'h0, 32'h0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         check("sat_stall", 32'(bus.stall_cnt_o), (3 + i > 15) ? 32'd15 : 32'(3 + i));
      end
      check("sat_alu", bus.alu_result_o, 32'h55);
      check("sat_ctrl", 32'(bus.ctrl_o), 32'h4);

      // reset mid-operation with flush asserted
      rst         = 1'b1;
      bus.flush_i = 1'b1;
      tick();
      check("mid_rst_stall", 32'(bus.stall_cnt_o), 32'd0);
      check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
      check("mid_rst_alu", bus.alu_result_o, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/pipe_reg_em_skid.md
# pipe_reg_em_skid

Parametrised EX→MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble-safe control outputs. It sits between the execute and memory stages of the scalar/vector pipeline. It replaces the always-load stage register so that the memory stage can apply backpressure without a combinational ready path back into execute. A saturating stall counter supports performance measurement.

## Interface
- DATA_W, 32, width of ALU result and store data
- ADDR_W, 3, width of destination register address
- CTRL_W, 4, control bundle width; bit order {PCSrc, RegWrite, MemWrite, MemtoReg}
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  kill all held entries (synchronous)
- valid_i  in  1  upstream entry valid
- ready_o  out  1  stage can accept an entry
- ctrl_i  in  CTRL_W  control bits from EX
- alu_result_i  in  DATA_W  ALU result from EX
- write_data_i  in  DATA_W  store data from EX
- wa3_i  in  ADDR_W  destination register from EX
- valid_o  out  1  MEM-side entry valid
- ready_i  in  1  MEM stage accepts the entry
- ctrl_o  out  CTRL_W  control bits; forced to 0 when valid_o=0
- alu_result_o, write_data_o  out  DATA_W  held entry data
- wa3_o  out  ADDR_W  held entry destination
- count_o  out  2  occupancy: 0, 1 or 2
- stall_cnt_o  out  CNT_W  saturating count of backpressure cycles

## Operation
- Handshake events:
  - accept = valid_i & ready_o
  - send = valid_o & ready_i
- Storage: main register (drives the outputs) and skid register. Each holds {ctrl, alu_result, write_data, wa3}.
- States:
  - EMPTY (count 0)
  - ONE (main valid)
  - FULL (main and skid valid)
- Transitions:
  - EMPTY: accept → main ← in, go to ONE; otherwise stay in EMPTY.
  - ONE, accept & send: main ← in, stay in ONE.
  - ONE, accept & !send: skid ← in, go to FULL.
  - ONE, !accept & send: go to EMPTY.
  - ONE, neither: hold.
  - FULL: ready_o=0, so no accept. send → main ← skid, go to ONE; otherwise hold.
- Output decode:
  - ready_o = (state != FULL), decoded from state only. There is no combinational path from ready_i or valid_i to ready_o.
  - valid_o = (state != EMPTY).
  - ctrl_o = valid_o ? main.ctrl : 0. A bubble never asserts RegWrite/MemWrite/PCSrc.
  - Data outputs are don't-care when valid_o=0. The implementation holds the last main value.
- Flush: next state is EMPTY. Any accept in the same cycle is discarded, and any send in the same cycle still counts as consumed. Flush does not clear stall_cnt_o.
- Priority: rst > flush_i > normal operation.
- Stall counter: increments when valid_o & !ready_i. It saturates at 2^CNT_W−1 and is cleared only by rst.
- Entries leave in strict arrival order. No entry is duplicated or lost except on flush.

## Timing
- Reset state, registered at the edge where rst=1:
  - state EMPTY; main and skid registers 0
  - valid_o=0, ready_o=1, ctrl_o=0, data outputs 0
  - count_o=0, stall_cnt_o=0
- Latency: an entry accepted at edge N is on the outputs after edge N (1 cycle), matching the previous stage register.
- Throughput: 1 entry/cycle while ready_i stays high.
- Backpressure: after ready_i drops, at most 1 further entry is absorbed into skid. ready_o falls on the edge that fills skid.
- Recovery: after ready_i returns, ready_o rises one edge later (FULL→ONE).
- Reset mid-operation: held entries are dropped with no output transfer, and the counter clears.
- Simultaneous flush_i and rst: reset values apply.

## Test plan
- Reset: hold rst=1 for 2 cycles with valid_i=1 and ctrl_i=4'hF → valid_o=0, ctrl_o=0, ready_o=1, count_o=0, stall_cnt_o=0.
- Streaming: ready_i=1; present alu_result_i 0x10, 0x11, 0x12 on consecutive cycles → the same values appear on alu_result_o one cycle later each; ready_o stays 1; count_o=1.
- Backpressure:
  - Stimulus: ready_i=0; send A=0xA0 then B=0xB0; upstream holds C=0xC0 with valid_i=1.
  - After the B accept: ready_o=0, count_o=2, alu_result_o=0xA0.
  - Then raise ready_i=1: outputs A, B, C in order with no duplicates.
  - stall_cnt_o equals the number of cycles with valid_o=1 & ready_i=0.
- Flush in FULL with valid_i=1 → next cycle valid_o=0, ctrl_o=0, ready_o=1, count_o=0; the input is dropped; stall_cnt_o is unchanged.
- Bubble safety: valid_i=0 with ctrl_i=4'b1111 and wa3_i=3'd7 for 5 cycles → ctrl_o=0 and valid_o=0 throughout.
- Saturation with CNT_W=4: valid entry held and ready_i=0 for 20 cycles → stall_cnt_o reaches 15 and stays at 15.
